resp_demux2_tracker: RTL and testbench

Response-path companion of the two-channel request multiplexer in the low-latency interconnect. It sits between the 2:1 request mux output and a TCDM-style target. It records which channel (CH0/CH1) owns each accepted request in an in-order tag FIFO, then steers each returning response to that channel. It also back-pressures the request path when the number of outstanding transactions reaches the FIFO depth.

---
 rtl/resp_demux_pkg.sv | 8 +
 rtl/resp_tag_fifo.sv | 54 +++++
 rtl/resp_demux2_tracker.sv | 71 +++++++
 tb/tb_resp_demux2_tracker.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/resp_demux_pkg.sv
// Shared types for the two-channel response demux.
// ch_tag_t identifies the channel that owns an outstanding request:
//   CH0_TAG (0) -> channel 0, CH1_TAG (1) -> channel 1.
package resp_demux_pkg;
  typedef logic ch_tag_t;
  localparam ch_tag_t CH0_TAG = 1'b0;
  localparam ch_tag_t CH1_TAG = 1'b1;
endpackage

// File: rtl/resp_tag_fifo.sv
// In-order tag FIFO, DEPTH x 1 bit, synchronous, async active-low reset.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   push, wdata     : write wdata at the tail (caller guarantees ~full)
//   pop             : drop the head entry (caller guarantees ~empty)
//   rdata           : head tag, straight from storage
//   full, empty     : decoded from the registered occupancy count
//   count           : occupancy, 0..DEPTH
module resp_tag_fifo
  import resp_demux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  ch_tag_t                wdata,
  output ch_tag_t                rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/resp_demux2_tracker.sv
// Response-path tracker for a 2:1 request mux in front of a TCDM-style target.
// Accepted requests push their channel tag into an in-order FIFO; each
// returning response pops the head tag and is steered to that channel.
// Requests are back-pressured when FIFO_DEPTH transactions are outstanding.
// Optional macro RESP_ORPHAN_CHECK_EN adds the sticky resp_orphan_o flag.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   data_req_i, data_sel_i      : request and granted channel from the mux
//   data_gnt_o                  : grant back to the mux
//   data_req_o, data_gnt_i      : request to / grant from the target
//   data_r_valid_i, _rdata_i    : response from the target
//   data_r_valid_CHx_o, _rdata  : steered response per channel
//   resp_orphan_o               : (RESP_ORPHAN_CHECK_EN) response seen while empty
module resp_demux2_tracker
  import resp_demux_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_sel_i,
  output logic                  data_gnt_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  output logic                  data_r_valid_CH0_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_CH0_o,
  output logic                  data_r_valid_CH1_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_CH1_o
`ifdef RESP_ORPHAN_CHECK_EN
  ,
  output logic                  resp_orphan_o
`endif
);
  logic    full, empty, push, pop;
  ch_tag_t head;

  // full is registered-only, so the response valid never reaches data_req_o;
  // the cost is that a pop at full cannot admit a push in the same cycle.
  assign data_req_o = data_req_i & ~full;
  assign data_gnt_o = data_gnt_i & ~full;
  assign push       = data_req_i & data_gnt_i & ~full;
  assign pop        = data_r_valid_i & ~empty;

  assign data_r_valid_CH0_o = pop & (head == CH0_TAG);
  assign data_r_valid_CH1_o = pop & (head == CH1_TAG);
  assign data_r_rdata_CH0_o = data_r_rdata_i;
  assign data_r_rdata_CH1_o = data_r_rdata_i;

  resp_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (ch_tag_t'(data_sel_i)),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count ()
  );

`ifdef RESP_ORPHAN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       resp_orphan_o <= 1'b0;
    else if (data_r_valid_i && empty) resp_orphan_o <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_resp_demux2_tracker.sv
module tb_resp_demux2_tracker;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_i = 0, sel_i = 0, gnt_i = 0, rv_i = 0;
  logic [DW-1:0] rd_i = '0;
  logic          gnt_o, req_o, v0, v1;
  logic [DW-1:0] rd0, rd1;
`ifdef RESP_ORPHAN_CHECK_EN
  logic          orphan;
`endif

  resp_demux2_tracker #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req_i), .data_sel_i(sel_i), .data_gnt_o(gnt_o),
    .data_req_o(req_o), .data_gnt_i(gnt_i),
    .data_r_valid_i(rv_i), .data_r_rdata_i(rd_i),
    .data_r_valid_CH0_o(v0), .data_r_rdata_CH0_o(rd0),
    .data_r_valid_CH1_o(v1), .data_r_rdata_CH1_o(rd1)
`ifdef RESP_ORPHAN_CHECK_EN
    , .resp_orphan_o(orphan)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit q[$];          // outstanding channel tags, oldest first
  bit orphan_m = 0;  // expected sticky orphan flag
  logic last_v0, last_v1, last_req;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare all outputs against the tag-queue model for the current input
  // set, then advance the model by what the coming clock edge will do.
  task automatic compare_and_update();
    bit full, pop, head, push;
    full = (q.size() == DEPTH);
    pop  = rv_i && (q.size() != 0);
    head = (q.size() != 0) ? q[0] : 1'b0;
    push = req_i && gnt_i && !full;
    chk("data_req_o", req_o, req_i && !full);
    chk("data_gnt_o", gnt_o, gnt_i && !full);
    chk("valid_ch0", v0, pop && !head);
    chk("valid_ch1", v1, pop && head);
    chk("rdata_ch0", rd0, rd_i);
    chk("rdata_ch1", rd1, rd_i);
`ifdef RESP_ORPHAN_CHECK_EN
    chk("resp_orphan", orphan, orphan_m);
`endif
    last_v0 = v0; last_v1 = v1; last_req = req_o;
    if (!rst_n) begin
      q.delete();
      orphan_m = 0;
    end else begin
      if (rv_i && q.size() == 0) orphan_m = 1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(sel_i);
    end
  endtask

  task automatic step(input bit req, input bit sel, input bit gnt, input bit rv,
                      input logic [DW-1:0] rd);
    @(negedge clk);
    req_i = req; sel_i = sel; gnt_i = gnt; rv_i = rv; rd_i = rd;
    #1;
    compare_and_update();
  endtask

  // Assert reset mid-cycle with the given inputs live, check the outputs
  // while reset is held, release it at the following negedge.
  task automatic do_reset(input bit req, input bit gnt, input bit rv);
    @(negedge clk);
    req_i = req; sel_i = 1'b1; gnt_i = gnt; rv_i = rv; rd_i = 32'h5A5A_0000;
    #1;
    rst_n = 1'b0;
    q.delete();
    orphan_m = 0;
    #1;
    compare_and_update();
    @(negedge clk);
    req_i = 0; gnt_i = 0; rv_i = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset(1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, '0);

    // single accept sel=1, response two cycles later
    step(1, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 32'hDEADBEEF);
    chk("t1_ch1_valid", {31'b0, last_v1}, 1);
    chk("t1_ch0_valid", {31'b0, last_v0}, 0);
    chk("t1_rdata", rd1, 32'hDEADBEEF);
    step(0, 0, 0, 0, '0);
    chk("t1_ch1_single", {31'b0, last_v1}, 0);

    // four back-to-back accepts, then ordered responses
    step(1, 0, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    chk("t2_req_blocked", {31'b0, last_req}, 0);
    step(0, 0, 0, 1, 32'h10); chk("t2_r0_ch0", {31'b0, last_v0}, 1);
    step(0, 0, 0, 1, 32'h11); chk("t2_r1_ch1", {31'b0, last_v1}, 1);
    step(0, 0, 0, 1, 32'h12); chk("t2_r2_ch1", {31'b0, last_v1}, 1);
    step(0, 0, 0, 1, 32'h13); chk("t2_r3_ch0", {31'b0, last_v0}, 1);

    // full with pop and request in the same cycle
    for (int i = 0; i < DEPTH; i++) step(1, i[0], 1, 0, '0);
    step(1, 1, 1, 1, 32'hA0);
    chk("t3_blocked_at_pop", {31'b0, last_req}, 0);
    step(1, 1, 1, 0, '0);
    chk("t3_accept_after_pop", {31'b0, last_req}, 1);
    step(1, 0, 1, 0, '0);
    chk("t3_full_again", {31'b0, last_req}, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 32'hB0 + i);

    // sustained push+pop with pointer wrap at a steady occupancy of 3
    for (int i = 0; i < DEPTH - 1; i++) step(1, i[0], 1, 0, '0);
    for (int i = 0; i < 20; i++) step(1, 1'($urandom), 1, 1, 32'h100 + i);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 1, 32'h200 + i);

    // orphan response while empty
    step(0, 0, 0, 1, 32'hBAD);
    chk("t5_orphan_no_ch0", {31'b0, last_v0}, 0);
    chk("t5_orphan_no_ch1", {31'b0, last_v1}, 0);
    step(0, 0, 0, 0, '0);
`ifdef RESP_ORPHAN_CHECK_EN
    chk("t5_orphan_set", {31'b0, orphan}, 1);
`endif
    step(1, 0, 1, 0, '0);
    step(0, 0, 0, 1, 32'hC0);
    chk("t5_after_orphan_ch0", {31'b0, last_v0}, 1);

    // reset with the FIFO full: occupancy clears immediately
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    chk("t6_full_before_rst", {31'b0, last_req}, 0);
    do_reset(1'b1, 1'b1, 1'b1);
    chk("t6_req_in_rst", {31'b0, last_req}, 1);
    step(0, 0, 0, 1, 32'hD0);
    chk("t6_orphan_ch1", {31'b0, last_v1}, 0);
    step(1, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 32'hE0);
    chk("t6_tracked_ch1", {31'b0, last_v1}, 1);
    step(0, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
